// File: rtl/prince_sbox_seq.sv
// prince_sbox_seq: issue/write-back sequencer for one 16-nibble masked PRINCE S-box layer.
// Define PRINCE_SEQ_ABORT_EN to add the abort input.
module prince_sbox_seq #(
  parameter int LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rnd_valid,
`ifdef PRINCE_SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic       rnd_ack,
  output logic [3:0] in_sel,
  output logic       in_valid,
  output logic       wb_en,
  output logic [3:0] wb_idx,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t             r_state;
  logic [3:0]         r_iss_cnt;
  logic [3:0]         r_wb_cnt;
  logic [LATENCY-1:0] r_dv;
  logic [3:0]         r_di [LATENCY];
  logic               w_abort;
  logic               w_issue;
  logic               w_kill;
`ifdef PRINCE_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  assign w_issue  = (r_state == ISSUE) && rnd_valid;
  assign w_kill   = w_abort && (r_state != IDLE);
  assign in_valid = w_issue;
  assign rnd_ack  = w_issue;
  assign in_sel   = r_iss_cnt;
  assign wb_en    = r_dv[LATENCY-1];
  assign wb_idx   = r_di[LATENCY-1];
  assign busy     = r_state != IDLE;
  assign done     = r_state == DONE;
  // the issue counter parks at 15 once the last nibble is issued, so it never wraps mid-layer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_kill) begin
      r_state   <= IDLE;
      r_iss_cnt <= '0;
      r_wb_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state   <= ISSUE;
          r_iss_cnt <= '0;
          r_wb_cnt  <= '0;
        end
        ISSUE: if (rnd_valid) begin
          if (r_iss_cnt == 4'd15) r_state <= DRAIN;
          else r_iss_cnt <= r_iss_cnt + 4'd1;
        end
        DRAIN: r_state <= DRAIN;
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (wb_en) r_wb_cnt <= r_wb_cnt + 4'd1;
      if (wb_en && r_wb_cnt == 4'd15) r_state <= DONE;
    end
  end
  // bubbles travel down the delay line too, keeping write-back exactly LATENCY cycles behind issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_kill) begin
      r_dv <= '0;
      for (int i = 0; i < LATENCY; i++) r_di[i] <= '0;
    end else begin
      r_dv[0] <= w_issue;
      r_di[0] <= w_issue ? r_iss_cnt : 4'd0;
      for (int i = 1; i < LATENCY; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_di[i] <= r_di[i-1];
      end
    end
  end
endmodule

// File: tb/tb_prince_sbox_seq.sv
// tb_prince_sbox_seq: scoreboard bench for prince_sbox_seq at LATENCY 4, 1 and 8.
module tb_prince_sbox_seq;
  typedef struct {int dut; int idx; int cyc;} ev_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] rv_v = '0;
`ifdef PRINCE_SEQ_ABORT_EN
  logic [2:0] abort_v = '0;
`endif
  logic [2:0] rnd_ack_v, in_valid_v, wb_en_v, busy_v, done_v;
  logic [3:0] in_sel_v [3];
  logic [3:0] wb_idx_v [3];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  ev_t        iq[$];
  ev_t        wq[$];
  ev_t        dq[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    prince_sbox_seq #(.LATENCY(g == 0 ? 4 : (g == 1 ? 1 : 8))) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start_v[g]),
      .rnd_valid(rv_v[g]),
`ifdef PRINCE_SEQ_ABORT_EN
      .abort(abort_v[g]),
`endif
      .rnd_ack(rnd_ack_v[g]),
      .in_sel(in_sel_v[g]),
      .in_valid(in_valid_v[g]),
      .wb_en(wb_en_v[g]),
      .wb_idx(wb_idx_v[g]),
      .busy(busy_v[g]),
      .done(done_v[g])
    );
  end
  function automatic int lat(input int d);
    return d == 0 ? 4 : (d == 1 ? 1 : 8);
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic cmp_ev(input string name, input ev_t e, input int g, input int idx, input bit ok);
    checks++;
    if (e.dut != g || e.idx != idx || e.cyc != cyc || !ok) begin
      errors++;
      $display("FAIL %s: got dut%0d idx %0d cyc %0d ok %0d expected dut%0d idx %0d cyc %0d",
               name, g, idx, cyc, ok, e.dut, e.idx, e.cyc);
    end
  endtask
  // monitor: every DUT event must match the head of its expectation queue
  always @(negedge clk) begin
    ev_t e;
    for (int g = 0; g < 3; g++) begin
      if (in_valid_v[g] || rnd_ack_v[g]) begin
        e = (iq.size() == 0) ? '{-1, -1, -1} : iq.pop_front();
        cmp_ev("issue", e, g, int'(in_sel_v[g]), in_valid_v[g] && rnd_ack_v[g]);
      end
      if (wb_en_v[g]) begin
        e = (wq.size() == 0) ? '{-1, -1, -1} : wq.pop_front();
        cmp_ev("writeback", e, g, int'(wb_idx_v[g]), 1'b1);
      end
      if (done_v[g]) begin
        e = (dq.size() == 0) ? '{-1, -1, -1} : dq.pop_front();
        cmp_ev("done", e, g, 0, 1'b1);
      end
    end
  end
  task automatic check_empty();
    chk("issue_q_drained", iq.size(), 0);
    chk("wb_q_drained", wq.size(), 0);
    chk("done_q_drained", dq.size(), 0);
    iq.delete();
    wq.delete();
    dq.delete();
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // s is the cycle that follows the start-sampling edge; sk1/sk2 are nibble indices to bubble once (-1 = none)
  task automatic layer_body(input int d, input int s, input int sk1, input int sk2);
    int k = 0;
    int nb;
    bit b1 = 0;
    bit b2 = 0;
    nb = (sk1 >= 0 ? 1 : 0) + (sk2 >= 0 ? 1 : 0);
    dq.push_back('{d, 0, s + 16 + lat(d) + nb});
    chk("busy_in_layer", busy_v[d], 1);
    while (k < 16) begin
      if (k == sk1 && !b1) begin
        b1 = 1;
        rv_v[d] = 1'b0;
      end else if (k == sk2 && !b2) begin
        b2 = 1;
        rv_v[d] = 1'b0;
      end else begin
        rv_v[d] = 1'b1;
        iq.push_back('{d, k, cyc});
        wq.push_back('{d, k, cyc + lat(d)});
        k++;
      end
      tick();
    end
    rv_v[d] = 1'b1;
    while (cyc < s + 17 + lat(d) + nb) tick();
    rv_v[d] = 1'b0;
    chk("busy_after_done", busy_v[d], 0);
    check_empty();
  endtask
  task automatic run(input int d, input int sk1, input int sk2, input bit hold);
    start_v[d] = 1'b1;
    tick();
    if (!hold) start_v[d] = 1'b0;
    layer_body(d, cyc, sk1, sk2);
  endtask
  initial begin
    int s;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", busy_v[d], 0);
      chk("rst_done", done_v[d], 0);
      chk("rst_in_valid", in_valid_v[d], 0);
      chk("rst_wb_en", wb_en_v[d], 0);
      chk("rst_in_sel", in_sel_v[d], 0);
      chk("rst_wb_idx", wb_idx_v[d], 0);
    end
    rst_n = 1'b1;
    rv_v = '1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) chk("idle_rnd_ack", rnd_ack_v[d], 0);
    rv_v = '0;
    run(0, -1, -1, 0);
    run(0, 3, 9, 0);
    run(0, -1, -1, 1);
    tick();
    start_v[0] = 1'b0;
    layer_body(0, cyc, -1, -1);
    // reset after seven issues: only write-backs already due before it may appear
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      rv_v[0] = 1'b1;
      iq.push_back('{0, k, cyc});
      if (k + lat(0) < 7) wq.push_back('{0, k, cyc + lat(0)});
      tick();
    end
    rv_v[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_in_valid", in_valid_v[0], 0);
    chk("async_rnd_ack", rnd_ack_v[0], 0);
    chk("async_wb_en", wb_en_v[0], 0);
    chk("async_busy", busy_v[0], 0);
    chk("async_done", done_v[0], 0);
    chk("async_in_sel", in_sel_v[0], 0);
    chk("async_wb_idx", wb_idx_v[0], 0);
    tick();
    rst_n = 1'b1;
    rv_v[0] = 1'b1;
    repeat (20) tick();
    rv_v[0] = 1'b0;
    check_empty();
    run(0, -1, -1, 0);
    run(1, -1, -1, 0);
    run(2, -1, -1, 0);
    run(1, 0, 15, 0);
    run(2, 7, 8, 0);
`ifdef PRINCE_SEQ_ABORT_EN
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    s = cyc;
    for (int k = 0; k < 16; k++) begin
      rv_v[0] = 1'b1;
      iq.push_back('{0, k, cyc});
      if (k + lat(0) <= 17) wq.push_back('{0, k, cyc + lat(0)});
      tick();
    end
    rv_v[0] = 1'b0;
    tick();
    chk("abort_cycle", cyc, s + 17);
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    chk("abort_busy", busy_v[0], 0);
    chk("abort_wb_en", wb_en_v[0], 0);
    chk("abort_done", done_v[0], 0);
    repeat (12) tick();
    check_empty();
    run(0, -1, -1, 0);
`else
    s = cyc;
    chk("cycle_advanced", s > 0 ? 1 : 0, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
